// File: rtl/pc_trace_sampler.sv
// Decimating pc trace sampler: takes one pc every DIV enabled cycles into a FWFT FIFO
// drained over valid/ready, and flags any cycle where pc does not advance by exactly +1.
module pc_trace_sampler #(
  parameter int DEPTH = 8,
  parameter int DIV   = 4
) (
  input  logic                       clkin,
  input  logic                       rst,
  input  logic [31:0]                pc_in,
  input  logic                       sample_en,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_pc,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow,
  output logic [15:0]                drop_cnt,
  output logic                       step_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  // A one-bit divider is kept for DIV=1 so the compare below stays well-formed.
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_div_cnt;
  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          r_overflow;
  logic [15:0]   r_drop_cnt;
  logic [31:0]   r_prev_pc;
  logic          r_prev_vld;
  logic          r_step_err;

  logic w_strobe;
  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_strobe = sample_en && (r_div_cnt == CW'(DIV - 1));
  assign w_full   = (r_level == LW'(DEPTH));
  assign w_empty  = (r_level == '0);
  assign w_pop    = !w_empty && out_ready;
  // A pop on the same edge frees the slot, so a full FIFO can still accept the sample.
  assign w_push   = w_strobe && (!w_full || w_pop);
  assign w_drop   = w_strobe && w_full && !w_pop;

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      r_div_cnt <= '0;
    end else if (sample_en) begin
      if (w_strobe) r_div_cnt <= '0;
      else          r_div_cnt <= r_div_cnt + CW'(1);
    end
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= pc_in;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  // The wrap from 32'hFFFFFFFF to 0 is a legal step since the add is mod 2^32.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      r_prev_pc  <= '0;
      r_prev_vld <= 1'b0;
      r_step_err <= 1'b0;
    end else begin
      r_prev_pc  <= pc_in;
      r_prev_vld <= 1'b1;
      r_step_err <= r_prev_vld && (pc_in != (r_prev_pc + 32'd1));
    end
  end

  assign out_valid = !w_empty;
  assign out_pc    = r_mem[r_rd_ptr];
  assign level     = r_level;
  assign overflow  = r_overflow;
  assign drop_cnt  = r_drop_cnt;
  assign step_err  = r_step_err;

endmodule

// File: tb/tb_pc_trace_sampler.sv
// Directed bench for pc_trace_sampler (DEPTH=8, DIV=4): decimation order, overflow,
// full-with-pop, step checker wrap and pulse, sample_en stall, and mid-run reset.
module tb_pc_trace_sampler;

  logic        clkin = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        sample_en;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [3:0]  level;
  logic        overflow;
  logic [15:0] drop_cnt;
  logic        step_err;

  int checks   = 0;
  int failures = 0;
  bit auto_inc = 1'b1;

  logic [31:0] seq [11];
  logic        seq_err [11];

  pc_trace_sampler #(.DEPTH(8), .DIV(4)) dut (
    .clkin     (clkin),
    .rst       (rst),
    .pc_in     (pc_in),
    .sample_en (sample_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .level     (level),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt),
    .step_err  (step_err)
  );

  always #5 clkin = ~clkin;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: inputs present at the edge are consumed, outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clkin);
    #1;
    if (auto_inc) pc_in = pc_in + 32'd1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    pc_in = 32'd0;
    @(posedge clkin);
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_level", {28'd0, level}, 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_drop", {16'd0, drop_cnt}, 32'd0);
    chk("rst_serr", {31'd0, step_err}, 32'd0);
    @(posedge clkin);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pc_in = 32'd0; sample_en = 1'b0; out_ready = 1'b0;

    // Samples 3,7,11 stream straight through with the consumer always ready.
    do_reset();
    sample_en = 1'b1; out_ready = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("t1_valid", {31'd0, out_valid}, (k % 4 == 0) ? 32'd1 : 32'd0);
      chk("t1_level", {28'd0, level}, (k % 4 == 0) ? 32'd1 : 32'd0);
      if (k % 4 == 0) chk("t1_pc", out_pc, 32'(k - 1));
    end

    // Ten strobes into eight slots: two drops, then drain in order.
    do_reset();
    sample_en = 1'b1; out_ready = 1'b0;
    repeat (40) tick();
    chk("t2_level", {28'd0, level}, 32'd8);
    chk("t2_ovf", {31'd0, overflow}, 32'd1);
    chk("t2_drop", {16'd0, drop_cnt}, 32'd2);
    chk("t2_head", out_pc, 32'd3);
    sample_en = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t2_valid", {31'd0, out_valid}, 32'd1);
      chk("t2_pc", out_pc, 32'(3 + 4 * i));
      tick();
    end
    chk("t2_empty", {31'd0, out_valid}, 32'd0);
    chk("t2_level0", {28'd0, level}, 32'd0);

    // Full FIFO with a pop on the strobe edge keeps level at 8 and drops nothing.
    do_reset();
    sample_en = 1'b1; out_ready = 1'b0;
    repeat (32) tick();
    chk("t3_full", {28'd0, level}, 32'd8);
    repeat (3) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t3_level", {28'd0, level}, 32'd8);
    chk("t3_drop", {16'd0, drop_cnt}, 32'd0);
    chk("t3_ovf", {31'd0, overflow}, 32'd0);
    sample_en = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t3_pc", out_pc, 32'(7 + 4 * i));
      tick();
    end
    chk("t3_empty", {31'd0, out_valid}, 32'd0);

    // Wrap through zero is clean; the 5->9 jump pulses step_err for one cycle.
    do_reset();
    auto_inc = 1'b0;
    sample_en = 1'b0; out_ready = 1'b0;
    seq     = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'd0, 32'd1, 32'd2, 32'd3,
                32'd4, 32'd5, 32'd9, 32'd10, 32'd11};
    seq_err = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 11; i++) begin
      pc_in = seq[i];
      tick();
      chk("t4_serr", {31'd0, step_err}, {31'd0, seq_err[i]});
    end
    auto_inc = 1'b1;

    // Three disabled cycles stretch the first strobe from edge 4 to edge 7.
    do_reset();
    sample_en = 1'b1; out_ready = 1'b1;
    repeat (2) begin tick(); chk("t5_pre", {31'd0, out_valid}, 32'd0); end
    sample_en = 1'b0;
    repeat (3) begin tick(); chk("t5_hold", {31'd0, out_valid}, 32'd0); end
    sample_en = 1'b1;
    tick();
    chk("t5_e6", {31'd0, out_valid}, 32'd0);
    tick();
    chk("t5_e7v", {31'd0, out_valid}, 32'd1);
    chk("t5_e7pc", out_pc, 32'd6);
    repeat (3) begin tick(); chk("t5_gap", {31'd0, out_valid}, 32'd0); end
    tick();
    chk("t5_e11v", {31'd0, out_valid}, 32'd1);
    chk("t5_e11pc", out_pc, 32'd10);

    // Asynchronous reset with level=5 and overflow set clears everything at once.
    do_reset();
    sample_en = 1'b1; out_ready = 1'b0;
    repeat (40) tick();
    sample_en = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
    chk("t6_level5", {28'd0, level}, 32'd5);
    chk("t6_ovf1", {31'd0, overflow}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_level", {28'd0, level}, 32'd0);
    chk("t6_ovf", {31'd0, overflow}, 32'd0);
    chk("t6_drop", {16'd0, drop_cnt}, 32'd0);
    @(posedge clkin);
    #1;
    chk("t6_next_valid", {31'd0, out_valid}, 32'd0);
    pc_in = 32'd1000;
    rst = 1'b0;
    tick();
    chk("t6_serr_first", {31'd0, step_err}, 32'd0);
    tick();
    chk("t6_serr_second", {31'd0, step_err}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
